// File: rtl/seg7_scan_reader.sv
// Recovers hex digits from a scanned active-low 7-segment bus and publishes whole frames.
// Latency: capture STABLE_CYCLES edges after the last input change, publish one edge later; no backpressure.
module seg7_scan_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     dig_sel_n,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     blank_mask,
    output logic                  frame_valid,
    output logic                  frame_err
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = DIGITS + 7;

    typedef enum logic {
        SETTLE,
        HOLD
    } state_t;

    typedef struct packed {
        logic [3:0] nib;
        logic       blank;
        logic       bad;
    } dec_t;

    function automatic dec_t decode(input logic [6:0] s);
        dec_t d;
        d = '0;
        case (s)
            7'h40: d.nib = 4'h0;
            7'h79: d.nib = 4'h1;
            7'h24: d.nib = 4'h2;
            7'h30: d.nib = 4'h3;
            7'h19: d.nib = 4'h4;
            7'h12: d.nib = 4'h5;
            7'h02: d.nib = 4'h6;
            7'h78: d.nib = 4'h7;
            7'h00: d.nib = 4'h8;
            7'h10: d.nib = 4'h9;
            7'h08: d.nib = 4'hA;
            7'h03: d.nib = 4'hB;
            7'h46: d.nib = 4'hC;
            7'h21: d.nib = 4'hD;
            7'h06: d.nib = 4'hE;
            7'h0E: d.nib = 4'hF;
            7'h7F: d.blank = 1'b1;
            default: d.bad = 1'b1;
        endcase
        return d;
    endfunction

    state_t                state_q, state_d;
    logic [IW-1:0]         in_reg_q, in_reg_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DIGITS-1:0]     seen_q, seen_d;
    logic [4*DIGITS-1:0]   stage_nib_q, stage_nib_d;
    logic [DIGITS-1:0]     stage_blank_q, stage_blank_d;
    logic                  stage_err_q, stage_err_d;
    logic                  pub_q, pub_d;
    logic [4*DIGITS-1:0]   value_q, value_d;
    logic [DIGITS-1:0]     blank_q, blank_d;
    logic                  fvld_q, fvld_d;
    logic                  ferr_q, ferr_d;

    logic [IW-1:0]         in_now;
    logic                  changed;
    logic                  capture;
    logic [DIGITS-1:0]     sel_lo;
    logic                  one_hot;
    dec_t                  dec;

    always_comb begin
        in_now  = {dig_sel_n, seg};
        changed = (in_now != in_reg_q);
        capture = !changed && (state_q == SETTLE) &&
                  ((cnt_q + CW'(1)) == CW'(STABLE_CYCLES));
        sel_lo  = ~dig_sel_n;
        one_hot = (sel_lo != '0) && ((sel_lo & (sel_lo - DIGITS'(1))) == '0);
        dec     = decode(seg);
    end

    // Input stability tracking: any change restarts the quiet-cycle count.
    always_comb begin
        in_reg_d = in_now;
        cnt_d    = cnt_q;
        state_d  = state_q;
        if (changed) begin
            cnt_d   = '0;
            state_d = SETTLE;
        end else if (state_q == SETTLE) begin
            if (cnt_q < CW'(STABLE_CYCLES)) begin
                cnt_d = cnt_q + CW'(1);
            end
            if (capture) begin
                state_d = HOLD;
            end
        end
    end

    // Staging: the publish edge restarts seen/err so a same-edge capture belongs to the next frame.
    always_comb begin
        seen_d        = pub_q ? '0 : seen_q;
        stage_err_d   = pub_q ? 1'b0 : stage_err_q;
        stage_nib_d   = stage_nib_q;
        stage_blank_d = stage_blank_q;
        if (capture && (sel_lo != '0)) begin
            if (!one_hot) begin
                stage_err_d = 1'b1;
            end else begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (sel_lo[i]) begin
                        stage_nib_d[4*i +: 4] = dec.nib;
                        stage_blank_d[i]      = dec.blank;
                        seen_d[i]             = 1'b1;
                    end
                end
                if (dec.bad) begin
                    stage_err_d = 1'b1;
                end
            end
        end
        pub_d = capture && (&seen_d);
    end

    always_comb begin
        value_d = value_q;
        blank_d = blank_q;
        ferr_d  = ferr_q;
        fvld_d  = 1'b0;
        if (pub_q) begin
            value_d = stage_nib_q;
            blank_d = stage_blank_q;
            ferr_d  = stage_err_q;
            fvld_d  = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= SETTLE;
            in_reg_q      <= '1;
            cnt_q         <= '0;
            seen_q        <= '0;
            stage_nib_q   <= '0;
            stage_blank_q <= '0;
            stage_err_q   <= 1'b0;
            pub_q         <= 1'b0;
            value_q       <= '0;
            blank_q       <= '0;
            fvld_q        <= 1'b0;
            ferr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_reg_q      <= in_reg_d;
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            stage_nib_q   <= stage_nib_d;
            stage_blank_q <= stage_blank_d;
            stage_err_q   <= stage_err_d;
            pub_q         <= pub_d;
            value_q       <= value_d;
            blank_q       <= blank_d;
            fvld_q        <= fvld_d;
            ferr_q        <= ferr_d;
        end
    end

    assign value       = value_q;
    assign blank_mask  = blank_q;
    assign frame_valid = fvld_q;
    assign frame_err   = ferr_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader with DIGITS=4, STABLE_CYCLES=4.
module tb_seg7_scan_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic [6:0]  seg;
    logic [3:0]  dig_sel_n;
    logic [15:0] value;
    logic [3:0]  blank_mask;
    logic        frame_valid;
    logic        frame_err;

    int tests = 0;
    int fails = 0;
    int fv_cnt = 0;
    int fv0;

    seg7_scan_reader #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .seg         (seg),
        .dig_sel_n   (dig_sel_n),
        .value       (value),
        .blank_mask  (blank_mask),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (frame_valid === 1'b1) fv_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic show(input logic [3:0] sel, input logic [6:0] s, input int n);
        dig_sel_n = sel;
        seg       = s;
        tick(n);
    endtask

    initial begin
        reset     = 1'b1;
        dig_sel_n = 4'hF;
        seg       = 7'h7F;
        tick(3);
        check("rst_value", value, 16'h0000);
        check("rst_blank", blank_mask, 4'h0);
        check("rst_fvalid", frame_valid, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        reset = 1'b0;
        tick(2);

        // basic frame 4321
        fv0 = fv_cnt;
        show(4'hE, 7'h79, 6);
        show(4'hD, 7'h24, 6);
        show(4'hB, 7'h30, 6);
        show(4'h7, 7'h19, 6);
        show(4'hF, 7'h7F, 4);
        check("basic_pulses", fv_cnt - fv0, 1);
        check("basic_value", value, 16'h4321);
        check("basic_blank", blank_mask, 4'h0);
        check("basic_ferr", frame_err, 1'b0);

        // stability boundary: S-1 matching edges after change is not enough
        fv0 = fv_cnt;
        show(4'hE, 7'h40, 6);
        show(4'hD, 7'h79, 6);
        show(4'hB, 7'h24, 6);
        show(4'h7, 7'h12, 4);
        show(4'hF, 7'h7F, 6);
        check("short_hold_no_frame", fv_cnt - fv0, 0);
        dig_sel_n = 4'h7;
        seg       = 7'h00;
        tick(5);
        check("capture_not_early", frame_valid, 1'b0);
        tick(1);
        check("capture_at_k_plus_s", frame_valid, 1'b1);
        check("hold_value", value, 16'h8210);
        show(4'hF, 7'h7F, 4);
        check("hold_pulses", fv_cnt - fv0, 1);

        // blank digit
        fv0 = fv_cnt;
        show(4'hE, 7'h0E, 6);
        show(4'hD, 7'h0E, 6);
        show(4'hB, 7'h7F, 6);
        show(4'h7, 7'h0E, 6);
        show(4'hF, 7'h7F, 4);
        check("blank_pulses", fv_cnt - fv0, 1);
        check("blank_value", value, 16'hF0FF);
        check("blank_mask", blank_mask, 4'b0100);
        check("blank_ferr", frame_err, 1'b0);

        // undecodable pattern, then a clean frame
        show(4'hE, 7'h55, 6);
        show(4'hD, 7'h79, 6);
        show(4'hB, 7'h24, 6);
        show(4'h7, 7'h30, 6);
        show(4'hF, 7'h7F, 4);
        check("bad_value", value, 16'h3210);
        check("bad_ferr", frame_err, 1'b1);
        show(4'hE, 7'h79, 6);
        show(4'hD, 7'h24, 6);
        show(4'hB, 7'h30, 6);
        show(4'h7, 7'h19, 6);
        show(4'hF, 7'h7F, 4);
        check("clean_value", value, 16'h4321);
        check("clean_ferr", frame_err, 1'b0);

        // multi-hot select and all-ones select do not mark digits seen
        fv0 = fv_cnt;
        show(4'hC, 7'h40, 6);
        show(4'hF, 7'h79, 6);
        show(4'hB, 7'h02, 6);
        show(4'h7, 7'h78, 6);
        show(4'hE, 7'h19, 6);
        show(4'hF, 7'h7F, 4);
        check("multihot_no_frame", fv_cnt - fv0, 0);
        show(4'hD, 7'h12, 6);
        show(4'hF, 7'h7F, 4);
        check("multihot_pulses", fv_cnt - fv0, 1);
        check("multihot_value", value, 16'h7654);
        check("multihot_ferr", frame_err, 1'b1);

        // reset after two digits discards them
        show(4'hE, 7'h08, 6);
        show(4'hD, 7'h03, 6);
        show(4'hF, 7'h7F, 2);
        reset = 1'b1;
        tick(2);
        check("midrst_value", value, 16'h0000);
        check("midrst_blank", blank_mask, 4'h0);
        check("midrst_ferr", frame_err, 1'b0);
        check("midrst_fvalid", frame_valid, 1'b0);
        reset = 1'b0;
        tick(2);
        fv0 = fv_cnt;
        show(4'hB, 7'h46, 6);
        show(4'h7, 7'h21, 6);
        show(4'hF, 7'h7F, 4);
        check("midrst_partial", fv_cnt - fv0, 0);
        show(4'hE, 7'h06, 6);
        show(4'hD, 7'h0E, 6);
        show(4'hF, 7'h7F, 4);
        check("midrst_pulses", fv_cnt - fv0, 1);
        check("midrst_new_value", value, 16'hDCFE);
        check("midrst_new_ferr", frame_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
